// File: rtl/wb_byte_bridge.sv
// wb_byte_bridge: byte-serial host command/response to 32-bit Wishbone master bridge (optional timeout: WB_BRIDGE_TIMEOUT_EN)
module wb_byte_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    input  logic        rsp_ready,
    output logic        wb_CYC,
    output logic        wb_STB,
    output logic        wb_WE,
    output logic [3:0]  wb_SEL,
    output logic [13:0] wb_ADR,
    output logic [31:0] wb_DAT_MOSI,
    input  logic [31:0] wb_DAT_MISO,
    input  logic        wb_ACK,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, ADR_LO, WDATA, BUS, RSP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [13:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rdat_q, rdat_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [2:0]  left_q, left_d;
    logic        cyc_q, cyc_d;
    logic        rdy_q, rdy_d;
    logic        rv_q, rv_d;
    logic [7:0]  rd_q, rd_d;
    logic        cmd_fire, rsp_fire, tmo_hit;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
        $error("TIMEOUT_CYCLES must be within 2..255");
    end

    assign cmd_fire    = cmd_valid && rdy_q;
    assign rsp_fire    = rv_q && rsp_ready;
    assign cmd_ready   = rdy_q;
    assign rsp_valid   = rv_q;
    assign rsp_data    = rd_q;
    assign wb_CYC      = cyc_q;
    assign wb_STB      = cyc_q;
    assign wb_WE       = we_q;
    assign wb_SEL      = 4'hF;
    assign wb_ADR      = adr_q;
    assign wb_DAT_MOSI = wdat_q;
    assign busy        = state_q != IDLE;

`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TMO = TIMEOUT_CYCLES[7:0];
    logic [7:0] tmo_q, tmo_d;
    // ACK has priority: the abort only fires on a cycle with no ACK
    assign tmo_hit = state_q == BUS && !wb_ACK && (tmo_q + 8'd1 == TMO);
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state, frame assembly and response sequencing
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        bcnt_d  = bcnt_q;
        left_d  = left_q;
        cyc_d   = cyc_q;
        rv_d    = rv_q;
        rd_d    = rd_q;
`ifdef WB_BRIDGE_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: if (cmd_fire) begin
                we_d    = cmd_data[7];
                adr_d   = {cmd_data[5:0], adr_q[7:0]};
                state_d = ADR_LO;
            end
            ADR_LO: if (cmd_fire) begin
                adr_d[7:0] = cmd_data;
                bcnt_d     = 2'd0;
                state_d    = we_q ? WDATA : BUS;
                cyc_d      = !we_q;
`ifdef WB_BRIDGE_TIMEOUT_EN
                tmo_d      = 8'd0;
`endif
            end
            WDATA: if (cmd_fire) begin
                wdat_d = {cmd_data, wdat_q[31:8]};
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
`ifdef WB_BRIDGE_TIMEOUT_EN
                    tmo_d   = 8'd0;
`endif
                end
            end
            BUS: begin
`ifdef WB_BRIDGE_TIMEOUT_EN
                tmo_d = tmo_q + 8'd1;
`endif
                if (wb_ACK || tmo_hit) begin
                    state_d = RSP;
                    cyc_d   = 1'b0;
                    rv_d    = 1'b1;
                    rd_d    = wb_ACK ? 8'h00 : 8'hEE;
                    rdat_d  = wb_DAT_MISO;
                    left_d  = (wb_ACK && !we_q) ? 3'd4 : 3'd0;
                end
            end
            RSP: if (rsp_fire) begin
                if (left_q == 3'd0) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    rd_d   = rdat_q[7:0];
                    rdat_d = {8'h00, rdat_q[31:8]};
                    left_d = left_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d = state_d == IDLE || state_d == ADR_LO || state_d == WDATA;
    end

    // State registers; reset abandons any frame or bus cycle in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            bcnt_q  <= '0;
            left_q  <= '0;
            cyc_q   <= 1'b0;
            rdy_q   <= 1'b0;
            rv_q    <= 1'b0;
            rd_q    <= '0;
`ifdef WB_BRIDGE_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            bcnt_q  <= bcnt_d;
            left_q  <= left_d;
            cyc_q   <= cyc_d;
            rdy_q   <= rdy_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
`ifdef WB_BRIDGE_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end
endmodule

// File: tb/tb_wb_byte_bridge.sv
// tb_wb_byte_bridge: directed self-checking bench for wb_byte_bridge
module tb_wb_byte_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_ready = 1'b0;
    logic        wb_CYC, wb_STB, wb_WE;
    logic [3:0]  wb_SEL;
    logic [13:0] wb_ADR;
    logic [31:0] wb_DAT_MOSI;
    logic [31:0] wb_DAT_MISO = 32'h0;
    logic        wb_ACK = 1'b0;
    logic        busy;
    int          vec = 0;
    int          miss = 0;

    always #5 clk = ~clk;

    wb_byte_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .wb_CYC(wb_CYC), .wb_STB(wb_STB), .wb_WE(wb_WE), .wb_SEL(wb_SEL),
        .wb_ADR(wb_ADR), .wb_DAT_MOSI(wb_DAT_MOSI), .wb_DAT_MISO(wb_DAT_MISO),
        .wb_ACK(wb_ACK), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_data  = b;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic rsp(input logic [7:0] b);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_data", 32'(rsp_data), 32'(b));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic ack(input int w);
        repeat (w) @(negedge clk);
        wb_ACK = 1'b1;
        @(negedge clk);
        wb_ACK = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int n;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_cyc", 32'(wb_CYC), 0);
        chk("rst_stb", 32'(wb_STB), 0);
        chk("rst_we", 32'(wb_WE), 0);
        chk("rst_adr", 32'(wb_ADR), 0);
        chk("rst_mosi", wb_DAT_MOSI, 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

        // write 0x0012 <= 0xDEADBEEF, ACK after 3 cycles
        send(8'h80); send(8'h12); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        chk("wr_cyc", 32'(wb_CYC), 1);
        chk("wr_stb", 32'(wb_STB), 1);
        chk("wr_we", 32'(wb_WE), 1);
        chk("wr_sel", 32'(wb_SEL), 32'hF);
        chk("wr_adr", 32'(wb_ADR), 32'h0012);
        chk("wr_mosi", wb_DAT_MOSI, 32'hDEADBEEF);
        chk("wr_cmd_ready", 32'(cmd_ready), 0);
        chk("wr_busy", 32'(busy), 1);
        repeat (2) begin
            @(negedge clk);
            chk("wr_hold_cyc", 32'(wb_STB), 1);
            chk("wr_hold_adr", 32'(wb_ADR), 32'h0012);
            chk("wr_hold_mosi", wb_DAT_MOSI, 32'hDEADBEEF);
            chk("wr_hold_rsp_valid", 32'(rsp_valid), 0);
        end
        ack(0);
        chk("wr_cyc_drop", 32'(wb_CYC), 0);
        chk("wr_stb_drop", 32'(wb_STB), 0);
        rsp(8'h00);
        chk("wr_rsp_done", 32'(rsp_valid), 0);
        chk("wr_turnaround", 32'(cmd_ready), 1);
        chk("wr_idle_busy", 32'(busy), 0);

        // read 0x3FFF, back-to-back response bytes
        wb_DAT_MISO = 32'h01234567;
        send(8'h3F); send(8'hFF);
        chk("rd_cyc", 32'(wb_CYC), 1);
        chk("rd_we", 32'(wb_WE), 0);
        chk("rd_adr", 32'(wb_ADR), 32'h3FFF);
        ack(0);
        wb_DAT_MISO = 32'hFFFFFFFF;
        chk("rd_cyc_drop", 32'(wb_CYC), 0);
        chk("rd_status_valid", 32'(rsp_valid), 1);
        chk("rd_status", 32'(rsp_data), 32'h00);
        rsp_ready = 1'b1;
        w = 32'h01234567;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rd_b2b_valid", 32'(rsp_valid), 1);
            chk("rd_b2b_data", 32'(rsp_data), 32'(w[8*i +: 8]));
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rd_done", 32'(rsp_valid), 0);
        chk("rd_turnaround", 32'(cmd_ready), 1);

        // backpressure read with a stray ACK during the response
        wb_DAT_MISO = 32'hAABBCCDD;
        send(8'h01); send(8'h05);
        chk("bp_adr", 32'(wb_ADR), 32'h0105);
        ack(0);
        wb_DAT_MISO = 32'h0;
        for (int i = 0; i < 5; i++) begin
            wb_ACK = (i == 2);
            chk("bp0_valid", 32'(rsp_valid), 1);
            chk("bp0_data", 32'(rsp_data), 32'h00);
            chk("bp0_cmd_ready", 32'(cmd_ready), 0);
            chk("bp0_cyc", 32'(wb_CYC), 0);
            @(negedge clk);
        end
        wb_ACK = 1'b0;
        rsp(8'h00);
        for (int i = 0; i < 5; i++) begin
            chk("bp1_data", 32'(rsp_data), 32'hDD);
            chk("bp1_cmd_ready", 32'(cmd_ready), 0);
            @(negedge clk);
        end
        rsp(8'hDD); rsp(8'hCC); rsp(8'hBB); rsp(8'hAA);
        chk("bp_done", 32'(rsp_valid), 0);

        // reset during the bus phase of a write
        send(8'h80); send(8'h00); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("rs_cyc_before", 32'(wb_CYC), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_cyc", 32'(wb_CYC), 0);
        chk("rs_stb", 32'(wb_STB), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_cmd_ready", 32'(cmd_ready), 0);
        chk("rs_mosi", wb_DAT_MOSI, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_cmd_ready_up", 32'(cmd_ready), 1);
        chk("rs_no_rsp", 32'(rsp_valid), 0);
        wb_ACK = 1'b1;
        repeat (2) @(negedge clk);
        wb_ACK = 1'b0;
        chk("idle_ack_busy", 32'(busy), 0);
        chk("idle_ack_cyc", 32'(wb_CYC), 0);
        chk("idle_ack_rsp", 32'(rsp_valid), 0);
        chk("idle_ack_ready", 32'(cmd_ready), 1);
        wb_DAT_MISO = 32'h55AA33CC;
        send(8'h00); send(8'h40);
        chk("rs_rd_adr", 32'(wb_ADR), 32'h0040);
        ack(1);
        rsp(8'h00); rsp(8'hCC); rsp(8'h33); rsp(8'hAA); rsp(8'h55);
        chk("rs_rd_done", 32'(rsp_valid), 0);

`ifdef WB_BRIDGE_TIMEOUT_EN
        // read with no ACK: abort after exactly 4 strobe cycles
        send(8'h00); send(8'h01);
        n = 0;
        while (wb_STB && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_stb_cycles", 32'(n), 4);
        rsp(8'hEE);
        chk("tmo_done", 32'(rsp_valid), 0);
        // ACK on the final allowed cycle wins
        wb_DAT_MISO = 32'h12345678;
        send(8'h00); send(8'h02);
        repeat (3) @(negedge clk);
        wb_ACK = 1'b1;
        @(negedge clk);
        wb_ACK = 1'b0;
        rsp(8'h00); rsp(8'h78); rsp(8'h56); rsp(8'h34); rsp(8'h12);
        send(8'h80); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("tmo_wr_mosi", wb_DAT_MOSI, 32'h04030201);
        ack(0);
        rsp(8'h00);
        chk("tmo_wr_done", 32'(rsp_valid), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
